unified_mem: RTL and testbench
==============================

Name: unified_mem

Overview:
- Word-addressed, unified instruction/data memory.
- It is the responder on the multicycle processor's memory bus (adr, writedata, memwrite, readdata).
- A byte-stream preload engine fills the array after reset, holding the processor in reset via cpu_hold until loading completes.
- After loading, it serves processor reads and writes.

Parameters:
- DATA_W, 16, processor data and word width.
- ADDR_W, 16, processor address width.
- DEPTH, 256, words in array; power of two; IDX_W = log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- adr  in  ADDR_W  word address from processor.
- writedata  in  DATA_W  store data from processor.
- memwrite  in  1  store strobe from processor.
- readdata  out  DATA_W  read data to processor.
- load_valid  in  1  preload byte valid.
- load_byte  in  8  preload byte.
- load_last  in  1  qualifies final byte of image, sampled with load_valid.
- load_ready  out  1  preload engine accepts a byte this cycle.
- cpu_hold  out  1  high = processor must be held in reset.
- load_done  out  1  high once in RUN.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous, active-high.
  - Reset forces state=LOAD, load_ptr=0, phase=HI, hi_byte=0.
  - Reset values: cpu_hold=1, load_ready=1, load_done=0, readdata=0.
  - Array contents are not reset.
- Index: idx = adr[IDX_W-1:0]. Upper address bits are ignored, so addresses alias modulo DEPTH.
- State LOAD:
  - load_ready=1, cpu_hold=1, readdata=0, memwrite ignored.
  - A byte is accepted when load_valid & load_ready.
  - phase HI: accepted byte goes to hi_byte, phase->LO.
  - phase LO: mem[load_ptr] <= {hi_byte, load_byte} on that edge; load_ptr++; phase->HI.
  - load_last on a HI byte: write {load_byte, 8'h00} immediately, then go to RUN (odd-length image).
  - load_last on a LO byte: write the word, then go to RUN.
  - A word write at load_ptr=DEPTH-1 goes to RUN regardless of load_last. There is no pointer wrap.
- State RUN:
  - load_ready=0, cpu_hold=0, load_done=1.
  - Bytes presented are not accepted.
  - readdata = mem[idx], combinational from adr (zero-latency read; the processor latches it at the end of its cycle).
  - memwrite=1 writes mem[idx] <= writedata on the rising edge.
  - A read of the same idx in the same cycle returns the old contents; the new value is visible the next cycle.
- Transition timing: LOAD->RUN occurs on the edge that writes the final word. cpu_hold falls in the following cycle, and the processor's first fetch sees the complete image.
- RUN is terminal; only reset returns to LOAD.
- Reset asserted mid-load: the partial word in hi_byte is discarded. Words already written stay in the array and are overwritten by the new load.
- Reset asserted in RUN: returns to LOAD with cpu_hold=1 asynchronously.
- Simultaneous events: the load_valid/load_last combination in RUN is ignored. memwrite in LOAD never modifies the array.

Decomposition:
- Shared package mem_pkg:
  - State enum {LOAD, RUN}.
  - Phase enum {HI, LO}.
  - Constant PAD_BYTE=8'h00.
  - Localparam helper for IDX_W.
- Sub-module mem_load_fsm owns the byte handshake, phase, hi_byte, load_ptr, state, and the cpu_hold/load_ready/load_done outputs. It emits a single internal write port (we, waddr, wdata).
- unified_mem instantiates mem_load_fsm and the array. The array write port is muxed: the loader's port in LOAD, the processor's port in RUN.

Test Plan:
- Reset, then stream bytes 12,34,56,78 with load_last on 78 -> mem[0]=16'h1234, mem[1]=16'h5678; cpu_hold falls the cycle after the 78 byte; readdata at adr=1 reads 16'h5678.
- Stream 3 bytes AB,CD,EF with load_last on EF -> mem[1]=16'hEF00; load_done=1; byte PAD_BYTE (8'h00) forms the low half.
- Stream 2*DEPTH bytes without load_last -> RUN entered after word DEPTH-1. A further byte gets load_ready=0 and is not accepted; mem[0] is unchanged.
- In RUN: adr=16'h0105 with DEPTH=256, memwrite=1, writedata=16'hBEEF -> mem[5]=16'hBEEF. Same-cycle readdata shows the old value; the next cycle shows 16'hBEEF.
- memwrite=1 during LOAD at adr=2, writedata=16'hFFFF -> mem[2] holds the loaded value, not 16'hFFFF.
- Assert reset after only byte 12 of a new load -> state LOAD, cpu_hold=1, load_ready=1. Restreaming 9A,BC gives mem[0]=16'h9ABC.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the unified instruction/data memory and its
// byte-stream preload engine.
package mem_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    HI = 1'b0,
    LO = 1'b1
  } phase_e;

  localparam logic [7:0] PAD_BYTE      = 8'h00;
  localparam int         DEPTH_DEFAULT = 256;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int IDX_W_DEFAULT = idx_w(DEPTH_DEFAULT);

endpackage : mem_pkg

// File: rtl/mem_load_fsm.sv
// Preload engine: packs big-endian byte pairs into words, writes them from
// index 0 upward, and releases the processor once the image is complete.
module mem_load_fsm
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int IDX_W = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid_i,
  input  logic [7:0]       load_byte_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic             cpu_hold_o,
  output logic             load_done_o,
  output logic             we_o,
  output logic [IDX_W-1:0] waddr_o,
  output logic [15:0]      wdata_o
);

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [7:0]       hi_byte_q, hi_byte_d;
  logic [IDX_W-1:0] load_ptr_q, load_ptr_d;
  logic             accept;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      phase_q    <= HI;
      hi_byte_q  <= 8'h00;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hi_byte_q  <= hi_byte_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  assign accept = load_valid_i && (state_q == LOAD);

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hi_byte_d  = hi_byte_q;
    load_ptr_d = load_ptr_q;
    we_o       = 1'b0;
    waddr_o    = load_ptr_q;
    wdata_o    = {hi_byte_q, load_byte_i};

    if (accept) begin
      if (phase_q == HI && !load_last_i) begin
        hi_byte_d = load_byte_i;
        phase_d   = LO;
      end else begin
        // A last byte arriving in the HI phase closes an odd-length image.
        we_o       = 1'b1;
        wdata_o    = (phase_q == HI) ? {load_byte_i, PAD_BYTE} : {hi_byte_q, load_byte_i};
        phase_d    = HI;
        load_ptr_d = load_ptr_q + IDX_W'(1);
        if (load_last_i || load_ptr_q == IDX_W'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
    end
  end

  assign load_ready_o = (state_q == LOAD);
  assign cpu_hold_o   = (state_q == LOAD);
  assign load_done_o  = (state_q == RUN);

endmodule : mem_load_fsm

// File: rtl/unified_mem.sv
// Word-addressed unified instruction/data memory: preloaded from a byte
// stream after reset, then serves processor reads (combinational) and writes.
module unified_mem
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] adr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  output logic [DATA_W-1:0] readdata,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic              load_done
);

  localparam int IDX_W = idx_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              ld_we;
  logic [IDX_W-1:0]  ld_waddr;
  logic [15:0]       ld_wdata;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              unused_adr_hi;

  // Upper address bits alias modulo DEPTH.
  assign idx           = adr[IDX_W-1:0];
  assign unused_adr_hi = ^adr[ADDR_W-1:IDX_W];

  mem_load_fsm #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_load_fsm (
    .clk          (clk),
    .reset        (reset),
    .load_valid_i (load_valid),
    .load_byte_i  (load_byte),
    .load_last_i  (load_last),
    .load_ready_o (load_ready),
    .cpu_hold_o   (cpu_hold),
    .load_done_o  (load_done),
    .we_o         (ld_we),
    .waddr_o      (ld_waddr),
    .wdata_o      (ld_wdata)
  );

  // Loader owns the write port until RUN; processor stores are dropped before.
  assign mem_we    = load_done ? memwrite  : ld_we;
  assign mem_waddr = load_done ? idx       : ld_waddr;
  assign mem_wdata = load_done ? writedata : DATA_W'(ld_wdata);

  // NOTE: the array has no reset so it maps onto plain RAM; its contents are
  // defined only by the preload image and later stores.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign readdata = load_done ? mem_q[idx] : '0;

endmodule : unified_mem

// File: tb/tb_unified_mem.sv
// Self-checking bench for unified_mem: a byte-queue reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_unified_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] adr = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic              memwrite = 1'b0;
  logic [DATA_W-1:0] readdata;
  logic              load_valid = 1'b0;
  logic [7:0]        load_byte = 8'h00;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              cpu_hold;
  logic              load_done;

  int checks   = 0;
  int failures = 0;

  unified_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adr        (adr),
    .writedata  (writedata),
    .memwrite   (memwrite),
    .readdata   (readdata),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes queue up and pair into words; the image ends on
  // load_last or when the array is full; afterwards the processor owns it.
  logic [DATA_W-1:0] m_mem   [DEPTH];
  bit                m_known [DEPTH];
  bit                m_run = 1'b0;
  int                m_ptr = 0;
  logic [7:0]        m_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0;
      m_ptr = 0;
      m_q.delete();
    end else if (!m_run) begin
      if (load_valid) begin
        m_q.push_back(load_byte);
        if (m_q.size() == 2 || load_last) begin
          m_mem[m_ptr]   = {m_q[0], (m_q.size() == 2) ? m_q[1] : 8'h00};
          m_known[m_ptr] = 1'b1;
          m_ptr++;
          m_q.delete();
          if (load_last || m_ptr == DEPTH) m_run = 1'b1;
        end
      end
    end else if (memwrite) begin
      m_mem[int'(adr) % DEPTH]   = writedata;
      m_known[int'(adr) % DEPTH] = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("cpu_hold", {31'd0, cpu_hold}, {31'd0, !m_run});
    check("load_ready", {31'd0, load_ready}, {31'd0, !m_run});
    check("load_done", {31'd0, load_done}, {31'd0, m_run});
    if (!m_run) check("readdata_load", {16'd0, readdata}, 32'd0);
    else if (m_known[int'(adr) % DEPTH]) check("readdata_run", {16'd0, readdata}, {16'd0, m_mem[int'(adr) % DEPTH]});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    memwrite = 1'b0;
    #1;
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_readdata", {16'd0, readdata}, 32'd0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic read_expect(input string name, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    adr = a;
    #1;
    check(name, {16'd0, readdata}, {16'd0, exp});
  endtask

  function automatic logic [7:0] stream_byte(input int i);
    return 8'((i * 7 + 3) & 8'hFF);
  endfunction

  initial begin
    step();
    do_reset();

    // Four-byte image.
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    send(8'h56, 1'b0);
    load_valid = 1'b1; load_byte = 8'h78; load_last = 1'b1;
    #1;
    check("hold_before_last_edge", {31'd0, cpu_hold}, 32'd1);
    step();
    load_valid = 1'b0; load_last = 1'b0;
    check("hold_after_last_edge", {31'd0, cpu_hold}, 32'd0);
    read_expect("img4_w1", 16'd1, 16'h5678);
    read_expect("img4_w0", 16'd0, 16'h1234);
    step();

    // Odd-length image pads the low half.
    do_reset();
    send(8'hAB, 1'b0);
    send(8'hCD, 1'b0);
    send(8'hEF, 1'b1);
    check("odd_load_done", {31'd0, load_done}, 32'd1);
    read_expect("odd_w0", 16'd0, 16'hABCD);
    read_expect("odd_w1", 16'd1, 16'hEF00);
    step();

    // Full image without load_last ends at the last word.
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) send(stream_byte(i), 1'b0);
    check("full_load_done", {31'd0, load_done}, 32'd1);
    load_valid = 1'b1; load_byte = 8'h55;
    #1;
    check("full_ready_low", {31'd0, load_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    read_expect("full_w0", 16'd0, 16'h030A);
    read_expect("full_wlast", 16'(DEPTH - 1), 16'hF5FC);

    // Aliased store: same-cycle read old, next cycle new.
    adr = 16'h0105; writedata = 16'hBEEF; memwrite = 1'b1;
    #1;
    check("store_same_cycle_old", {16'd0, readdata}, 32'h4950);
    step();
    memwrite = 1'b0;
    check("store_next_cycle_new", {16'd0, readdata}, 32'h0000BEEF);
    read_expect("store_alias_w5", 16'd5, 16'hBEEF);
    step();

    // Processor stores during LOAD are ignored.
    do_reset();
    adr = 16'd2; writedata = 16'hFFFF; memwrite = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("load_readdata_zero", {16'd0, readdata}, 32'd0);
    send(8'h55, 1'b0);
    load_valid = 1'b1; load_byte = 8'h66; load_last = 1'b1;
    @(posedge clk);
    memwrite = 1'b0;
    #1;
    load_valid = 1'b0; load_last = 1'b0;
    read_expect("ignore_store_w2", 16'd2, 16'h5566);
    step();

    // Reset mid-load discards the partial word.
    do_reset();
    send(8'h12, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    check("midrst_load_done", {31'd0, load_done}, 32'd0);
    step();
    reset = 1'b0;
    send(8'h9A, 1'b0);
    send(8'hBC, 1'b1);
    read_expect("midrst_w0", 16'd0, 16'h9ABC);
    step();

    // Reset in RUN asynchronously re-holds the processor.
    #2;
    reset = 1'b1;
    #1;
    check("runrst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    step();
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_unified_mem
